ad9914_spi_sequencer: RTL and testbench

Serial-port controller for the AD9914 DDS. It sits between the command-update logic and the DDS pins. On each load pulse it captures the frequency-sweep parameter set and writes it into the AD9914 digital-ramp-generator (DRG) registers as a fixed five-frame SPI burst, then pulses IO_UPDATE. It also drives DRCTL to start and stop the sweep on PRF/TR events, and refuses to corrupt a write in progress.

---
 rtl/ad9914_spi_sequencer_if.sv | 18 +
 rtl/ad9914_spi_sequencer.sv | 159 +++++++++++++++
 tb/tb_ad9914_spi_sequencer.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ad9914_spi_sequencer_if.sv
// AD9914 DDS pin bundle driven by the SPI sequencer.
interface ad9914_spi_sequencer_if;
    logic dds_cs_n;
    logic dds_sclk;
    logic dds_sdio;
    logic dds_io_update;
    logic dds_drctl;

    modport master (
        output dds_cs_n, dds_sclk, dds_sdio,
        output dds_io_update, dds_drctl
    );

    modport slave (
        input dds_cs_n, dds_sclk, dds_sdio,
        input dds_io_update, dds_drctl
    );
endinterface

// File: rtl/ad9914_spi_sequencer.sv
// AD9914 DRG register writer: five 40-bit SPI frames, IO_UPDATE, DRCTL control.
// Optional AD9914_DUAL_BAND_EN lets band_sel pick limit set 2 at capture.
module ad9914_spi_sequencer #(
    parameter int SCLK_DIV = 2,
    parameter int IOUP_W   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        sweep_start,
    input  logic        sweep_stop,
    input  logic        band_sel,
    input  logic [31:0] ftw_lower_1,
    input  logic [31:0] ftw_upper_1,
    input  logic [31:0] ftw_lower_2,
    input  logic [31:0] ftw_upper_2,
    input  logic [31:0] sweep_step,
    input  logic [15:0] sweep_rate,
    ad9914_spi_sequencer_if.master dds,
    output logic        busy,
    output logic        done,
    output logic        sweep_drop
);
    typedef enum logic [2:0] {
        IDLE, CS_SETUP, SHIFT, CS_GAP, IOUP, DONE
    } state_t;

    state_t      state, state_nx;
    logic [7:0]  div_cnt;
    logic [7:0]  ioup_cnt;
    logic [5:0]  bit_cnt;
    logic [2:0]  frame;
    logic        gap_cnt;
    logic        sclk_q;
    logic        pending;
    logic        drctl_q;
    logic        drop_q;
    logic [31:0] sh_lower, sh_upper, sh_step;
    logic [15:0] sh_rate;
    logic [31:0] sel_lower, sel_upper;
    logic [31:0] data;
    logic [39:0] word;
    logic        start;
    logic        div_last;
    logic        bit_last;
    logic        shifting;

`ifdef AD9914_DUAL_BAND_EN
    assign sel_lower = band_sel ? ftw_lower_2 : ftw_lower_1;
    assign sel_upper = band_sel ? ftw_upper_2 : ftw_upper_1;
`else
    logic unused_band;
    assign unused_band = ^{band_sel, ftw_lower_2, ftw_upper_2};
    assign sel_lower   = ftw_lower_1;
    assign sel_upper   = ftw_upper_1;
`endif

    assign div_last = (div_cnt == 8'(SCLK_DIV - 1));
    assign bit_last = (bit_cnt == 6'd39);
    assign shifting = (state == CS_SETUP) || (state == SHIFT);
    // A pending reload leaves DONE straight into the next burst.
    assign start = ((state == IDLE) || (state == DONE)) && (load || pending);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:     if (load || pending) state_nx = CS_SETUP;
            CS_SETUP: state_nx = SHIFT;
            SHIFT:    if (div_last && sclk_q && bit_last) state_nx = CS_GAP;
            CS_GAP:   if (gap_cnt) state_nx = (frame == 3'd4) ? IOUP : CS_SETUP;
            IOUP:     if (ioup_cnt == 8'(IOUP_W - 1)) state_nx = DONE;
            DONE:     state_nx = (load || pending) ? CS_SETUP : IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending  <= 1'b0;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            gap_cnt  <= 1'b0;
            ioup_cnt <= '0;
            frame    <= '0;
            sclk_q   <= 1'b0;
            drctl_q  <= 1'b0;
            drop_q   <= 1'b0;
        end else begin
            if (start)                     pending <= 1'b0;
            else if (load && state != IDLE) pending <= 1'b1;

            if (state == CS_SETUP) begin
                div_cnt <= '0;
                bit_cnt <= '0;
                sclk_q  <= 1'b0;
            end else if (state == SHIFT) begin
                if (div_last) begin
                    div_cnt <= '0;
                    sclk_q  <= ~sclk_q;
                    if (sclk_q && !bit_last) bit_cnt <= bit_cnt + 6'd1;
                end else begin
                    div_cnt <= div_cnt + 8'd1;
                end
            end

            gap_cnt  <= (state == CS_GAP) ? ~gap_cnt : 1'b0;
            ioup_cnt <= (state == IOUP) ? ioup_cnt + 8'd1 : 8'd0;

            if (start)
                frame <= '0;
            else if (state == CS_GAP && gap_cnt && frame != 3'd4)
                frame <= frame + 3'd1;

            // Starting a reload must never leave the DRG ramping.
            if (start)                      drctl_q <= 1'b0;
            else if (sweep_stop)            drctl_q <= 1'b0;
            else if (sweep_start && !busy)  drctl_q <= 1'b1;

            drop_q <= sweep_start && busy;
        end
    end

    always_ff @(posedge clk) begin
        if (start) begin
            sh_lower <= sel_lower;
            sh_upper <= sel_upper;
            sh_step  <= sweep_step;
            sh_rate  <= sweep_rate;
        end
    end

    always_comb begin
        unique case (frame)
            3'd0:       data = sh_lower;
            3'd1:       data = sh_upper;
            3'd2, 3'd3: data = sh_step;
            default:    data = {sh_rate, sh_rate};
        endcase
    end

    assign word = {1'b0, 7'h04 + {4'd0, frame}, data};

    assign dds.dds_cs_n      = ~shifting;
    assign dds.dds_sclk      = sclk_q;
    assign dds.dds_sdio      = shifting ? word[6'd39 - bit_cnt] : 1'b0;
    assign dds.dds_io_update = (state == IOUP);
    assign dds.dds_drctl     = drctl_q;

    assign busy = (state == CS_SETUP) || (state == SHIFT) ||
                  (state == CS_GAP) || (state == IOUP) ||
                  ((state == DONE) && pending);
    assign done       = (state == DONE);
    assign sweep_drop = drop_q;
endmodule

// File: tb/tb_ad9914_spi_sequencer.sv
// Bench for ad9914_spi_sequencer: SPI frame decoder, timing and DRCTL checks.
`timescale 1ns/1ps
module tb_ad9914_spi_sequencer;
    localparam int DIV0 = 2, IW0 = 4, DIV1 = 1, IW1 = 1;
    localparam int FRAME0 = 1 + 80 * DIV0 + 2;
    localparam int FRAME1 = 1 + 80 * DIV1 + 2;

    typedef struct {
        logic [31:0] lo;
        logic [31:0] up;
        logic [31:0] st;
        logic [15:0] rt;
    } par_t;

    typedef struct {
        logic start;
        logic stop;
        logic exp_drctl;
        logic exp_drop;
    } vec_t;

    logic clk = 0, rst = 1;
    logic load0 = 0, load1 = 0, sweep_start = 0, sweep_stop = 0, band_sel = 0;
    logic [31:0] lo1 = 0, up1 = 0, lo2 = 0, up2 = 0, step = 0;
    logic [15:0] rate = 0;
    logic busy0, done0, drop0, busy1, done1, drop1;
    int nchk = 0, nerr = 0;
    int cyc = 0;

    ad9914_spi_sequencer_if if0();
    ad9914_spi_sequencer_if if1();

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ad9914_spi_sequencer #(.SCLK_DIV(DIV0), .IOUP_W(IW0)) dut0 (
        .clk(clk), .rst(rst), .load(load0),
        .sweep_start(sweep_start), .sweep_stop(sweep_stop), .band_sel(band_sel),
        .ftw_lower_1(lo1), .ftw_upper_1(up1), .ftw_lower_2(lo2), .ftw_upper_2(up2),
        .sweep_step(step), .sweep_rate(rate), .dds(if0),
        .busy(busy0), .done(done0), .sweep_drop(drop0)
    );

    ad9914_spi_sequencer #(.SCLK_DIV(DIV1), .IOUP_W(IW1)) dut1 (
        .clk(clk), .rst(rst), .load(load1),
        .sweep_start(sweep_start), .sweep_stop(sweep_stop), .band_sel(band_sel),
        .ftw_lower_1(lo1), .ftw_upper_1(up1), .ftw_lower_2(lo2), .ftw_upper_2(up2),
        .sweep_step(step), .sweep_rate(rate), .dds(if1),
        .busy(busy1), .done(done1), .sweep_drop(drop1)
    );

    // SPI decoder and event log, one channel per DUT.
    logic m_cs[2], m_sclk[2], m_sdio[2], m_iou[2], m_done[2];
    assign m_cs[0] = if0.dds_cs_n;   assign m_cs[1] = if1.dds_cs_n;
    assign m_sclk[0] = if0.dds_sclk; assign m_sclk[1] = if1.dds_sclk;
    assign m_sdio[0] = if0.dds_sdio; assign m_sdio[1] = if1.dds_sdio;
    assign m_iou[0] = if0.dds_io_update; assign m_iou[1] = if1.dds_io_update;
    assign m_done[0] = done0; assign m_done[1] = done1;

    logic [39:0] fr0[256], fr1[256];
    logic [39:0] sh[2];
    int fcnt[2], partial[2], sdio_err[2], per_err[2], nb[2], last_rise[2];
    int done_cnt[2], done_cyc[2], iou_first[2], iou_last[2];
    bit pcs[2] = '{1'b1, 1'b1};
    bit psclk[2], psdio[2], piou[2];

    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (m_sdio[g] !== psdio[g] && m_sclk[g]) sdio_err[g] <= sdio_err[g] + 1;
            if (!m_cs[g] && pcs[g]) begin
                nb[g] <= 0;
            end else if (!m_cs[g] && m_sclk[g] && !psclk[g]) begin
                if (nb[g] > 0 && cyc - last_rise[g] != 2 * (g == 0 ? DIV0 : DIV1))
                    per_err[g] <= per_err[g] + 1;
                last_rise[g] <= cyc;
                sh[g] <= {sh[g][38:0], m_sdio[g]};
                nb[g] <= nb[g] + 1;
            end else if (m_cs[g] && !pcs[g]) begin
                if (nb[g] == 40) begin
                    if (g == 0) fr0[fcnt[0] % 256] <= sh[0];
                    else        fr1[fcnt[1] % 256] <= sh[1];
                    fcnt[g] <= fcnt[g] + 1;
                end else if (nb[g] != 0) begin
                    partial[g] <= partial[g] + 1;
                end
                nb[g] <= 0;
            end
            if (m_iou[g] && !piou[g]) iou_first[g] <= cyc;
            if (!m_iou[g] && piou[g]) iou_last[g] <= cyc - 1;
            if (m_done[g]) begin
                done_cnt[g] <= done_cnt[g] + 1;
                done_cyc[g] <= cyc;
            end
            pcs[g] <= m_cs[g];
            psclk[g] <= m_sclk[g];
            psdio[g] <= m_sdio[g];
            piou[g] <= m_iou[g];
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] pick(input logic b, input logic [31:0] a1, a2);
`ifdef AD9914_DUAL_BAND_EN
        return b ? a2 : a1;
`else
        return a1;
`endif
    endfunction

    function automatic par_t snap();
        par_t p;
        p.lo = pick(band_sel, lo1, lo2);
        p.up = pick(band_sel, up1, up2);
        p.st = step;
        p.rt = rate;
        return p;
    endfunction

    // Register write i of a burst: write bit, address 0x04+i, 32 data bits.
    function automatic logic [39:0] exp_frame(input int i, input par_t p);
        logic [31:0] d;
        case (i)
            0: d = p.lo;
            1: d = p.up;
            2, 3: d = p.st;
            default: d = {p.rt, p.rt};
        endcase
        return {1'b0, 7'(4 + i), d};
    endfunction

    task automatic rand_params();
        lo1 = $urandom; up1 = $urandom; lo2 = $urandom; up2 = $urandom;
        step = $urandom; rate = 16'($urandom); band_sel = 1'($urandom);
    endtask

    task automatic check_frames(input int g, input int base, input par_t p, input string tag);
        for (int i = 0; i < 5; i++)
            chk($sformatf("%s_frame%0d", tag, i),
                64'(g == 0 ? fr0[(base + i) % 256] : fr1[(base + i) % 256]),
                64'(exp_frame(i, p)));
    endtask

    task automatic start0(output int lc);
        @(negedge clk); load0 = 1;
        @(posedge clk); #1; load0 = 0;
        lc = cyc - 1;
    endtask

    task automatic wait_done(input int g, input int target, input int bound, input string nm);
        int n = 0;
        while (done_cnt[g] < target && n < bound) begin
            @(negedge clk); #1; n++;
        end
        chk({nm, "_reached"}, 64'(done_cnt[g] >= target), 64'd1);
    endtask

    task automatic run_case(input int nextra, input string tag);
        int lc, db, fb, n, gaps, nb_exp;
        int t[3];
        par_t p1, p2;
        rand_params();
        p1 = snap(); p2 = p1;
        db = done_cnt[0]; fb = fcnt[0];
        nb_exp = (nextra > 0) ? 2 : 1;
        for (int k = 0; k < 3; k++) t[k] = 50 + 200 * k + int'($urandom_range(0, 100));
        start0(lc);
        n = 0; gaps = 0;
        while (done_cnt[0] < db + nb_exp && n < 4000) begin
            @(negedge clk); #1; n++;
            if (load0) begin load0 = 0; rand_params(); p2 = snap(); end
            if (n == 10) rand_params();
            for (int k = 0; k < nextra; k++) if (n == t[k]) load0 = 1;
            if (done_cnt[0] < db + nb_exp && !busy0) gaps++;
        end
        load0 = 0;
        chk({tag, "_reached"}, 64'(done_cnt[0] >= db + nb_exp), 64'd1);
        chk({tag, "_busy_gap"}, 64'(gaps), 64'd0);
        repeat (20) @(negedge clk);
        #1;
        chk({tag, "_bursts"}, 64'(done_cnt[0] - db), 64'(nb_exp));
        chk({tag, "_frames"}, 64'(fcnt[0] - fb), 64'(5 * nb_exp));
        check_frames(0, fb, p1, {tag, "_b1"});
        if (nextra > 0) check_frames(0, fb + 5, p2, {tag, "_b2"});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[7];
        par_t pd;
        int lc, db, fb, pb;

        vt[0] = '{1'b1, 1'b0, 1'b1, 1'b0};
        vt[1] = '{1'b0, 1'b0, 1'b1, 1'b0};
        vt[2] = '{1'b1, 1'b1, 1'b0, 1'b0};
        vt[3] = '{1'b1, 1'b0, 1'b1, 1'b0};
        vt[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        vt[5] = '{1'b0, 1'b0, 1'b0, 1'b0};
        vt[6] = '{1'b1, 1'b0, 1'b1, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs",
            64'({if0.dds_cs_n, if0.dds_sclk, if0.dds_sdio, if0.dds_io_update,
                 if0.dds_drctl, busy0, done0, drop0}), 64'h80);
        @(negedge clk); rst = 0;

        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            sweep_start = vt[i].start; sweep_stop = vt[i].stop;
            @(posedge clk); #1;
            chk($sformatf("idle_vec%0d_drctl", i), 64'(if0.dds_drctl), 64'(vt[i].exp_drctl));
            chk($sformatf("idle_vec%0d_drop", i), 64'(drop0), 64'(vt[i].exp_drop));
        end
        @(negedge clk); sweep_start = 0; sweep_stop = 0;

        // Directed burst with known register values.
        lo1 = 32'h11223344; up1 = 32'h55667788; step = 32'h00000100; rate = 16'h0010;
        lo2 = 32'hDEADBEEF; up2 = 32'hCAFEF00D; band_sel = 0;
        pd = '{32'h11223344, 32'h55667788, 32'h00000100, 16'h0010};
        db = done_cnt[0]; fb = fcnt[0];
        start0(lc);
        chk("cycle1_cs_busy", 64'({if0.dds_cs_n, busy0}), 64'b01);
        chk("load_clears_drctl", 64'(if0.dds_drctl), 64'd0);
        @(negedge clk); sweep_start = 1;
        @(posedge clk); #1;
        chk("busy_start_drop", 64'(drop0), 64'd1);
        chk("busy_start_drctl", 64'(if0.dds_drctl), 64'd0);
        @(negedge clk); sweep_start = 0;
        @(posedge clk); #1;
        chk("drop_one_cycle", 64'(drop0), 64'd0);
        wait_done(0, db + 1, 2000, "directed");
        chk("busy_low_at_done", 64'(busy0), 64'd0);
        chk("iou_first", 64'(iou_first[0] - lc), 64'(5 * FRAME0 + 1));
        chk("iou_last", 64'(iou_last[0] - lc), 64'(5 * FRAME0 + IW0));
        chk("done_cycle", 64'(done_cyc[0] - lc), 64'(5 * FRAME0 + IW0 + 1));
        repeat (5) @(negedge clk);
        check_frames(0, fb, pd, "directed");

        // Band select at capture.
        lo1 = 32'h01020304; lo2 = 32'hA0000000; band_sel = 1;
        pd = snap();
        db = done_cnt[0]; fb = fcnt[0];
        start0(lc);
        wait_done(0, db + 1, 2000, "band");
        repeat (5) @(negedge clk);
`ifdef AD9914_DUAL_BAND_EN
        chk("band_frame0_data", 64'(fr0[fb % 256][31:0]), 64'h A0000000);
`else
        chk("band_frame0_data", 64'(fr0[fb % 256][31:0]), 64'h01020304);
`endif
        check_frames(0, fb, pd, "band");

        // Loads during a burst collapse into one reload with the latest inputs.
        run_case(3, "reload3");

        // Load arriving exactly in the DONE cycle.
        rand_params();
        pd = snap();
        db = done_cnt[0]; fb = fcnt[0];
        start0(lc);
        wait_done(0, db + 1, 2000, "doneload_first");
        rand_params(); load0 = 1;
        begin
            par_t p2;
            p2 = snap();
            @(posedge clk); #1; load0 = 0;
            chk("doneload_restart", 64'({if0.dds_cs_n, busy0}), 64'b01);
            wait_done(0, db + 2, 2000, "doneload_second");
            repeat (5) @(negedge clk);
            check_frames(0, fb, pd, "doneload_b1");
            check_frames(0, fb + 5, p2, "doneload_b2");
        end

        for (int r = 0; r < 5; r++)
            run_case(int'($urandom_range(0, 2)), $sformatf("rand%0d", r));

        // Reset in the middle of the third frame.
        rand_params();
        pb = partial[0];
        start0(lc);
        repeat (2 * FRAME0 + 60 - 1) @(negedge clk);
        rst = 1;
        @(posedge clk); #1;
        chk("rst_mid_outputs",
            64'({if0.dds_cs_n, if0.dds_sclk, if0.dds_sdio, if0.dds_io_update,
                 if0.dds_drctl, busy0, done0, drop0}), 64'h80);
        @(negedge clk); rst = 0;
        run_case(0, "post_rst");
        chk("rst_partial_discarded", 64'(partial[0] - pb), 64'd1);

        // Fastest SCLK instance.
        rand_params();
        pd = snap();
        db = done_cnt[1]; fb = fcnt[1];
        @(negedge clk); load1 = 1;
        @(posedge clk); #1; load1 = 0; lc = cyc - 1;
        wait_done(1, db + 1, 1000, "div1");
        chk("div1_iou_first", 64'(iou_first[1] - lc), 64'(5 * FRAME1 + 1));
        chk("div1_done_cycle", 64'(done_cyc[1] - lc), 64'(5 * FRAME1 + IW1 + 1));
        repeat (5) @(negedge clk);
        #1;
        chk("div1_idle_flags", 64'({busy1, drop1}), 64'd0);
        check_frames(1, fb, pd, "div1");

        chk("sdio_stable_div2", 64'(sdio_err[0]), 64'd0);
        chk("sdio_stable_div1", 64'(sdio_err[1]), 64'd0);
        chk("sclk_period_div2", 64'(per_err[0]), 64'd0);
        chk("sclk_period_div1", 64'(per_err[1]), 64'd0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
